// File: rtl/simon_pkg.sv
// ============================================================================
//  Module      : simon_pkg
//  Description : Shared state encoding, colour codes and LFSR taps for the
//                Simon memory-game sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simon_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SHOW = 3'd2,
        GAP  = 3'd3,
        WAIT = 3'd4,
        WIN  = 3'd5,
        LOSE = 3'd6
    } state_t;

    localparam logic [1:0] COL_RED    = 2'b00;
    localparam logic [1:0] COL_BLUE   = 2'b01;
    localparam logic [1:0] COL_YELLOW = 2'b10;
    localparam logic [1:0] COL_GREEN  = 2'b11;

    // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

`default_nettype wire

// File: rtl/simon_lfsr16.sv
// ============================================================================
//  Module      : simon_lfsr16
//  Description : Free-running 16-bit Galois LFSR; a zero seed becomes 1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_lfsr16
    import simon_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    localparam logic [15:0] c_SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= c_SEED_SAFE;
        end else begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign lfsr = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/simon_sequencer.sv
// ============================================================================
//  Module      : simon_sequencer
//  Description : Simon game controller: grows, plays back and checks a colour
//                sequence. Optional WAIT timeout under SIMON_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_sequencer
    import simon_pkg::*;
#(
    parameter int          MAX_LEN        = 16,
    parameter int          SHOW_CYCLES    = 12000000,
    parameter int          GAP_CYCLES     = 4000000,
    parameter int          TIMEOUT_CYCLES = 120000000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           btn_valid,
    input  logic [1:0]                     btn_colour,
    output logic                           led_on,
    output logic [1:0]                     led_colour,
    output logic                           awaiting_input,
    output logic [$clog2(MAX_LEN+1)-1:0]   level,
    output logic                           win,
    output logic                           lose
);

    localparam int c_LW      = $clog2(MAX_LEN + 1);
    localparam int c_IW      = $clog2(MAX_LEN);
    localparam int c_TMAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int c_TMAX    = (TIMEOUT_CYCLES > c_TMAX_SG) ? TIMEOUT_CYCLES : c_TMAX_SG;
    localparam int c_TW      = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_TW-1:0] c_SHOW_LOAD = c_TW'(SHOW_CYCLES - 1);
    localparam logic [c_TW-1:0] c_GAP_LOAD  = c_TW'(GAP_CYCLES - 1);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [c_TW-1:0] c_TO_LOAD   = c_TW'(TIMEOUT_CYCLES - 1);
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_TW-1:0]   r_timer;
    logic [c_TW-1:0]   w_timer_load;
    logic [c_LW-1:0]   r_level;
    logic [c_IW-1:0]   r_idx;
    logic [1:0]        r_seq [MAX_LEN];
    logic [15:0]       w_lfsr;
    logic              w_unused_lfsr;
    logic              w_hit;
    logic              w_last;
    logic              w_enter;

    simon_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:2];
    assign w_hit         = btn_valid && (btn_colour == r_seq[r_idx]);
    assign w_last        = (c_LW'(r_idx) + c_LW'(1)) == r_level;
    assign w_enter       = (w_state_nxt != r_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_load = '0;
        case (r_state)
            IDLE, WIN, LOSE: if (start) w_state_nxt = ADD;
            ADD:             w_state_nxt = SHOW;
            SHOW:            if (r_timer == '0) w_state_nxt = GAP;
            GAP:             if (r_timer == '0) w_state_nxt = w_last ? WAIT : SHOW;
            WAIT: begin
                // A press always wins over an expiring timer
                if (btn_valid) begin
                    if (!w_hit) begin
                        w_state_nxt = LOSE;
                    end else if (w_last) begin
                        w_state_nxt = (r_level == c_LW'(MAX_LEN)) ? WIN : ADD;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (r_timer == '0) begin
                    w_state_nxt = LOSE;
                end
`endif
            end
            default:         w_state_nxt = IDLE;
        endcase

        case (w_state_nxt)
            SHOW:    w_timer_load = c_SHOW_LOAD;
            GAP:     w_timer_load = c_GAP_LOAD;
`ifdef SIMON_TIMEOUT_EN
            WAIT:    w_timer_load = c_TO_LOAD;
`endif
            default: w_timer_load = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_level <= '0;
            r_idx   <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seq[i] <= COL_RED;
            end
        end else begin
            if (w_enter) begin
                r_timer <= w_timer_load;
            end
`ifdef SIMON_TIMEOUT_EN
            else if (r_state == WAIT && w_hit) begin
                r_timer <= c_TO_LOAD;
            end
`endif
            else if (r_timer != '0) begin
                r_timer <= r_timer - 1'b1;
            end

            case (r_state)
                IDLE, WIN, LOSE: begin
                    if (start) r_level <= '0;
                end
                ADD: begin
                    r_seq[r_level[c_IW-1:0]] <= w_lfsr[1:0];
                    r_level                  <= r_level + 1'b1;
                    r_idx                    <= '0;
                end
                GAP: begin
                    if (r_timer == '0) r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                WAIT: begin
                    if (w_hit && !w_last) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign led_on         = (r_state == SHOW);
    assign led_colour     = led_on ? r_seq[r_idx] : COL_RED;
    assign awaiting_input = (r_state == WAIT);
    assign level          = r_level;
    assign win            = (r_state == WIN);
    assign lose           = (r_state == LOSE);

endmodule

`default_nettype wire

// File: tb/tb_simon_sequencer.sv
// ============================================================================
//  Module      : tb_simon_sequencer
//  Description : Self-checking bench for simon_sequencer (vectors + random games).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_simon_sequencer;

    localparam int MAX_LEN = 4;
    localparam int SHOW_C  = 4;
    localparam int GAP_C   = 2;
    localparam int TO_C    = 20;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          btn_valid;
    logic [1:0]    btn_colour;
    logic          led_on;
    logic [1:0]    led_colour;
    logic          awaiting_input;
    logic [LW-1:0] level;
    logic          win;
    logic          lose;

    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_seq [$];
    int         colour_hist [4];

    typedef struct {
        logic       rst;
        logic       start;
        logic       bv;
        logic [1:0] col;
        logic       e_led;
        logic       e_wait;
        logic       e_win;
        logic       e_lose;
        int         e_level;
    } vec_t;

    vec_t vt [12];

    simon_sequencer #(
        .MAX_LEN        (MAX_LEN),
        .SHOW_CYCLES    (SHOW_C),
        .GAP_CYCLES     (GAP_C),
        .TIMEOUT_CYCLES (TO_C),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .btn_valid      (btn_valid),
        .btn_colour     (btn_colour),
        .led_on         (led_on),
        .led_colour     (led_colour),
        .awaiting_input (awaiting_input),
        .level          (level),
        .win            (win),
        .lose           (lose)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic press_step(input logic [1:0] col);
        btn_valid  = 1'b1;
        btn_colour = col;
        tick;
        btn_valid  = 1'b0;
    endtask

    task automatic drive_noise(input bit noise);
        if (noise) begin
            btn_valid  = ($urandom_range(0, 2) == 0);
            btn_colour = 2'($urandom_range(0, 3));
            start      = ($urandom_range(0, 4) == 0);
        end else begin
            btn_valid = 1'b0;
            start     = 1'b0;
        end
    endtask

    // Entered with the ADD cycle visible; leaves with the first WAIT cycle visible.
    task automatic watch_round(input int n, input bit noise);
        logic [1:0] col;
        col = 2'b00;
        chk("add_led", int'(led_on), 0);
        chk("add_wait", int'(awaiting_input), 0);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < SHOW_C; c++) begin
                drive_noise(noise);
                tick;
                chk("show_led", int'(led_on), 1);
                chk("show_level", int'(level), n);
                if (c == 0) col = led_colour;
                else        chk("show_hold", int'(led_colour), int'(col));
            end
            if (i < n - 1) begin
                chk("replay_colour", int'(col), int'(exp_seq[i]));
            end else begin
                exp_seq.push_back(col);
                colour_hist[col]++;
            end
            for (int g = 0; g < GAP_C; g++) begin
                drive_noise(noise);
                tick;
                chk("gap_led", int'(led_on), 0);
                chk("gap_colour", int'(led_colour), 0);
                chk("gap_wait", int'(awaiting_input), 0);
            end
        end
        btn_valid = 1'b0;
        start     = 1'b0;
        tick;
        chk("wait_enter", int'(awaiting_input), 1);
        chk("wait_level", int'(level), n);
        chk("wait_led", int'(led_on), 0);
    endtask

    task automatic do_presses(input int n, input int wrong_pos, input int xr, output bit lost);
        lost = 1'b0;
        for (int p = 0; p < n; p++) begin
            repeat ($urandom_range(0, 3)) begin
                tick;
                chk("wait_hold", int'(awaiting_input), 1);
            end
            if (p == wrong_pos) begin
                press_step(exp_seq[p] ^ 2'(xr));
                chk("lose_flag", int'(lose), 1);
                chk("lose_wait", int'(awaiting_input), 0);
                chk("lose_level", int'(level), n);
                chk("lose_win", int'(win), 0);
                lost = 1'b1;
                return;
            end
            press_step(exp_seq[p]);
            if (p < n - 1) begin
                chk("mid_wait", int'(awaiting_input), 1);
            end else if (n < MAX_LEN) begin
                chk("next_round_wait", int'(awaiting_input), 0);
                chk("next_round_level", int'(level), n);
            end else begin
                chk("win_flag", int'(win), 1);
                chk("win_level", int'(level), MAX_LEN);
                chk("win_lose", int'(lose), 0);
            end
        end
    endtask

    task automatic start_game;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_level", int'(level), 0);
        chk("start_win", int'(win), 0);
        chk("start_lose", int'(lose), 0);
        exp_seq.delete();
    endtask

    task automatic play_game(input int wrong_round, input int wrong_pos, input int xr, input bit noise);
        bit lost;
        lost = 1'b0;
        repeat ($urandom_range(0, 5)) tick;
        start_game();
        for (int n = 1; n <= MAX_LEN; n++) begin
            watch_round(n, noise);
            do_presses(n, (n == wrong_round) ? wrong_pos : -1, xr, lost);
            if (lost) break;
        end
        btn_valid  = 1'b1;
        btn_colour = 2'($urandom_range(0, 3));
        tick;
        btn_valid = 1'b0;
        tick;
        chk("terminal_hold_win", int'(win), lost ? 0 : 1);
        chk("terminal_hold_lose", int'(lose), lost ? 1 : 0);
    endtask

    initial begin
        int         wr;
        int         distinct;
        bit         lost;
        logic [1:0] tcol;

        rst        = 1'b1;
        start      = 1'b0;
        btn_valid  = 1'b0;
        btn_colour = 2'b00;
        foreach (colour_hist[i]) colour_hist[i] = 0;
        repeat (3) tick;
        chk("reset_led", int'(led_on), 0);
        chk("reset_level", int'(level), 0);
        rst = 1'b0;
        tick;
        chk("idle_wait", int'(awaiting_input), 0);
        chk("idle_win_lose", int'({win, lose}), 0);

        play_game(0, -1, 1, 1'b0);
        play_game(2, 1, 1, 1'b0);
        play_game(0, -1, 1, 1'b1);
        for (int g = 0; g < 6; g++) begin
            wr = $urandom_range(0, MAX_LEN);
            play_game(wr, (wr > 0) ? $urandom_range(0, wr - 1) : -1,
                      $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

        // Reset mid-game, then IDLE/SHOW/GAP vector table
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        chk("pre_reset_led", int'(led_on), 1);
        rst = 1'b1;
        #1;
        chk("async_reset_led", int'(led_on), 0);
        chk("async_reset_level", int'(level), 0);

        vt[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1};

        tcol = 2'b00;
        for (int i = 0; i < 12; i++) begin
            rst        = vt[i].rst;
            start      = vt[i].start;
            btn_valid  = vt[i].bv;
            btn_colour = vt[i].col;
            tick;
            chk($sformatf("vec%0d_led", i), int'(led_on), int'(vt[i].e_led));
            chk($sformatf("vec%0d_wait", i), int'(awaiting_input), int'(vt[i].e_wait));
            chk($sformatf("vec%0d_flags", i), int'({win, lose}), int'({vt[i].e_win, vt[i].e_lose}));
            chk($sformatf("vec%0d_level", i), int'(level), vt[i].e_level);
            if (i == 5) tcol = led_colour;
            else if (vt[i].e_led) chk($sformatf("vec%0d_colour", i), int'(led_colour), int'(tcol));
        end
        start     = 1'b0;
        btn_valid = 1'b0;
        exp_seq.delete();
        exp_seq.push_back(tcol);
        do_presses(1, 0, 1, lost);

        // WAIT timeout behaviour
        start_game();
        watch_round(1, 1'b0);
`ifdef SIMON_TIMEOUT_EN
        for (int j = 2; j <= TO_C; j++) begin
            tick;
            chk("timeout_hold", int'(awaiting_input), 1);
        end
        tick;
        chk("timeout_lose", int'(lose), 1);
        chk("timeout_wait", int'(awaiting_input), 0);
        start_game();
        watch_round(1, 1'b0);
        for (int j = 2; j <= TO_C; j++) tick;
        press_step(exp_seq[0]);
        chk("edge_press_accept", int'(awaiting_input), 0);
        chk("edge_press_lose", int'(lose), 0);
        chk("edge_press_level", int'(level), 1);
        watch_round(2, 1'b0);
        press_step(exp_seq[0]);
        chk("reload_mid_wait", int'(awaiting_input), 1);
        for (int j = 2; j <= TO_C; j++) begin
            tick;
            chk("reload_hold", int'(awaiting_input), 1);
        end
        press_step(exp_seq[1]);
        chk("reload_accept_lose", int'(lose), 0);
        chk("reload_accept_level", int'(level), 2);
        watch_round(3, 1'b0);
        do_presses(3, 0, 2, lost);
`else
        repeat (1000) tick;
        chk("no_timeout_wait", int'(awaiting_input), 1);
        chk("no_timeout_lose", int'(lose), 0);
        do_presses(1, -1, 1, lost);
        watch_round(2, 1'b0);
        do_presses(2, 1, 3, lost);
`endif

        distinct = 0;
        foreach (colour_hist[i]) if (colour_hist[i] > 0) distinct++;
        chk("colour_variety", int'(distinct >= 2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
- Game controller for the 4-colour memory game.
- Grows a pseudo-random colour sequence by one step per round and plays it back on the LED outputs.
- Accepts player presses as 2-bit colour codes from the colour decoder and compares each press against the stored sequence.
- Reports win or lose. Sits between the colour decoder and the LED/output drivers.

Parameters:
- MAX_LEN, 16, sequence length needed to win (2..32).
- SHOW_CYCLES, 12000000, clocks each colour is lit during playback.
- GAP_CYCLES, 4000000, clocks LEDs are dark after each shown colour.
- TIMEOUT_CYCLES, 120000000, clocks allowed between presses (used only with SIMON_TIMEOUT_EN).
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse that starts a new game.
- btn_valid, input, 1, one-cycle pulse for a debounced, edge-detected press.
- btn_colour, input, 2, colour code (00 red, 01 blue, 10 yellow, 11 green); sampled when btn_valid=1.
- led_on, output, 1, LED lit during SHOW.
- led_colour, output, 2, colour to light; 00 when led_on=0.
- awaiting_input, output, 1, high in WAIT.
- level, output, $clog2(MAX_LEN+1), current sequence length.
- win, output, 1, high in WIN state.
- lose, output, 1, high in LOSE state.

Behaviour:
- Reset values: state=IDLE, all outputs 0, level=0, idx=0, timers=0, sequence memory cleared to 00, LFSR=LFSR_SEED.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every clock in every state, so the start timing seeds randomness.
- IDLE: on start -> ADD.
- ADD (1 cycle):
  - seq[level] <= lfsr[1:0].
  - level <= level+1.
  - idx <= 0.
  - -> SHOW.
- SHOW:
  - led_on=1, led_colour=seq[idx].
  - Lasts exactly SHOW_CYCLES clocks, then -> GAP.
- GAP:
  - LEDs off for exactly GAP_CYCLES clocks.
  - Then idx+1 == level -> WAIT with idx=0; otherwise idx++ -> SHOW.
- WAIT:
  - awaiting_input=1.
  - btn_valid with btn_colour == seq[idx]:
    - idx == level-1 and level == MAX_LEN -> WIN.
    - idx == level-1 and level < MAX_LEN -> ADD.
    - otherwise idx++.
  - btn_valid with mismatch -> LOSE.
- WIN / LOSE:
  - Terminal; win or lose held at 1.
  - start -> clear level to 0, then ADD on the next cycle (same path as from IDLE).
- btn_valid outside WAIT: ignored.
- start outside IDLE/WIN/LOSE: ignored.
- Simultaneous start and btn_valid in WAIT: btn_valid handled, start ignored.
- Playback latency: first led_on cycle is 2 clocks after the start pulse (IDLE->ADD->SHOW).
- Timers:
  - One shared down-counter, loaded on every state entry.
  - Width $clog2 of the largest cycle parameter.
- rst asserted mid-game returns immediately to reset values; no partial state survives.

Optional Feature:
- Macro: SIMON_TIMEOUT_EN.
- Defined:
  - On entering WAIT and after each accepted press, the timer reloads TIMEOUT_CYCLES.
  - If it reaches 0 with no press -> LOSE.
  - A press in the expiry cycle takes precedence.
- Undefined: WAIT has no timeout; TIMEOUT_CYCLES is unused.

Decomposition:
- Package simon_pkg:
  - State enum: IDLE, ADD, SHOW, GAP, WAIT, WIN, LOSE.
  - Colour constants: COL_RED=2'b00, COL_BLUE=2'b01, COL_YELLOW=2'b10, COL_GREEN=2'b11.
  - LFSR tap mask constant.
- Sub-module simon_lfsr16: free-running Galois LFSR with seed parameter and zero-seed guard; output is the full 16-bit state.
- FSM, timer and sequence memory (MAX_LEN x 2-bit register array) stay in simon_sequencer.

Test Plan:
- Bench parameters: MAX_LEN=4, SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20.
- Reset/idle: assert rst mid-stream, then release -> all outputs 0, level=0; btn_valid pulses in IDLE cause no state change.
- Full win: start; bench records each led_colour while led_on=1 and echoes the sequence in WAIT each round. Required response:
  - level steps 1,2,3,4.
  - Each colour is lit exactly 4 cycles with 2 dark cycles between.
  - First led_on is 2 cycles after start.
  - win=1 after the 4th correct press of round 4.
- Wrong press: round 2, first press correct, second press = recorded colour XOR 2'b01 -> lose=1 next cycle, awaiting_input=0, level=2.
- Ignored input: btn_valid during SHOW/GAP -> no effect; sequence and level unchanged; the round still succeeds with correct presses.
- Restart: start while lose=1 -> level reads 1 after ADD, lose=0, new playback of length 1. Start asserted during SHOW is ignored.
- Timeout (SIMON_TIMEOUT_EN defined):
  - No press for 20 cycles in WAIT -> lose=1.
  - Press on the 20th cycle -> accepted.
  - Without the macro: wait 1000 cycles -> still awaiting_input=1.
